time_count: RTL and testbench

Real-time-of-day core for the calendar display path: a millisecond prescaler, a 1 Hz BCD time counter (00:00:00 to 23:59:59), and a button-driven set mode with a cursor. It sits directly upstream of the six-digit multiplexed display. It supplies the six BCD digits, the per-digit decimal-point pattern and the 1 ms scan-advance strobe (`MS_F`) that the display consumes.

---
 rtl/calendar_pkg.sv | 28 ++
 rtl/ms_tick_gen.sv | 29 ++
 rtl/time_count.sv | 135 +++++++++++++
 tb/tb_time_count.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared definitions for the calendar display path: mode enum, BCD digit limits,
// run-mode decimal-point pattern and a small BCD increment helper.
package calendar_pkg;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;

  localparam logic [3:0] SEC_L_MAX   = 4'd9;
  localparam logic [3:0] SEC_H_MAX   = 4'd5;
  localparam logic [3:0] MIN_L_MAX   = SEC_L_MAX;
  localparam logic [3:0] MIN_H_MAX   = SEC_H_MAX;
  localparam logic [3:0] HR_L_MAX    = 4'd9;
  localparam logic [3:0] HR_H_MAX    = 4'd2;
  localparam logic [3:0] HR_L_MAX_24 = 4'd3;

  // Per-digit rollover values while running; 23:59:59 is handled separately.
  localparam logic [5:0][3:0] RUN_MAX = {HR_H_MAX, HR_L_MAX, MIN_H_MAX,
                                         MIN_L_MAX, SEC_H_MAX, SEC_L_MAX};

  localparam logic [5:0] DP_RUN = 6'b10_1011;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: free-running divider producing a one-cycle registered
// strobe every MS_DIV clocks.
module ms_tick_gen #(
  parameter int MS_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic ms_f_o
);

  localparam int W = $clog2(MS_DIV);
  localparam logic [W-1:0] DIV_LAST = W'(MS_DIV - 1);

  logic [W-1:0] div_cnt_q;
  logic         ms_f_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      ms_f_q    <= 1'b0;
    end else begin
      ms_f_q    <= (div_cnt_q == DIV_LAST);
      div_cnt_q <= (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  assign ms_f_o = ms_f_q;

endmodule

// File: rtl/time_count.sv
// Time-of-day core: 1 Hz BCD counter 00:00:00..23:59:59 with a button-driven
// set mode, cursor and blinking decimal-point cursor indication.
module time_count
  import calendar_pkg::*;
#(
  parameter int MS_DIV     = 50000,
  parameter int MS_PER_SEC = 1000
) (
  input  logic       SYS_CLK,
  input  logic       EXT_RST_N,
  input  logic       SET_R,
  input  logic       LEFT_R,
  input  logic       RIGHT_R,
  input  logic       UP_R,
  output logic       MS_F,
  output logic [3:0] COUNT_SECL,
  output logic [3:0] COUNT_SECH,
  output logic [3:0] COUNT_MINL,
  output logic [3:0] COUNT_MINH,
  output logic [3:0] COUNT_HRL,
  output logic [3:0] COUNT_HRH,
  output logic [5:0] DISP_P
);

  localparam int MSW = $clog2(MS_PER_SEC);
  localparam logic [MSW-1:0] MS_LAST = MSW'(MS_PER_SEC - 1);
  localparam logic [MSW-1:0] MS_HALF = MSW'(MS_PER_SEC / 2);
  localparam logic [5:0][3:0] TIME_END = {4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9};

  mode_e            mode_q, mode_d;
  logic [2:0]       cursor_q, cursor_d;
  logic [MSW-1:0]   ms_cnt_q, ms_cnt_d;
  logic [5:0][3:0]  dig_q, dig_d;
  logic [5:0]       disp_q, disp_d;
  logic             sec_tick;
  logic             carry;
  logic             blink_low;

  ms_tick_gen #(.MS_DIV(MS_DIV)) u_ms_tick_gen (
    .clk_i  (SYS_CLK),
    .rst_ni (EXT_RST_N),
    .ms_f_o (MS_F)
  );

  always_comb begin
    mode_d   = mode_q;
    cursor_d = cursor_q;
    dig_d    = dig_q;
    ms_cnt_d = ms_cnt_q;
    carry    = 1'b1;
    sec_tick = MS_F && (ms_cnt_q == MS_LAST);

    if (MS_F) begin
      ms_cnt_d = (ms_cnt_q == MS_LAST) ? '0 : ms_cnt_q + 1'b1;
    end

    if (mode_q == MODE_RUN && sec_tick) begin
      if (dig_q == TIME_END) begin
        dig_d = '0;
      end else begin
        for (int i = 0; i < 6; i++) begin
          if (carry) begin
            if (dig_q[i] == RUN_MAX[i]) begin
              dig_d[i] = 4'd0;
            end else begin
              dig_d[i] = dig_q[i] + 4'd1;
              carry    = 1'b0;
            end
          end
        end
      end
    end

    // A set pulse swallows any cursor/up pulse arriving in the same cycle.
    if (SET_R) begin
      if (mode_q == MODE_RUN) begin
        mode_d   = MODE_SET;
        cursor_d = 3'd0;
      end else begin
        mode_d   = MODE_RUN;
        ms_cnt_d = '0;
      end
    end else if (mode_q == MODE_SET) begin
      if (LEFT_R && !RIGHT_R) begin
        cursor_d = (cursor_q == 3'd5) ? 3'd0 : cursor_q + 3'd1;
      end else if (RIGHT_R && !LEFT_R) begin
        cursor_d = (cursor_q == 3'd0) ? 3'd5 : cursor_q - 3'd1;
      end
      if (UP_R) begin
        case (cursor_q)
          3'd0: dig_d[0] = bcd_inc(dig_q[0], SEC_L_MAX);
          3'd1: dig_d[1] = bcd_inc(dig_q[1], SEC_H_MAX);
          3'd2: dig_d[2] = bcd_inc(dig_q[2], MIN_L_MAX);
          3'd3: dig_d[3] = bcd_inc(dig_q[3], MIN_H_MAX);
          3'd4: dig_d[4] = bcd_inc(dig_q[4], (dig_q[5] == HR_H_MAX) ? HR_L_MAX_24 : HR_L_MAX);
          3'd5: begin
            dig_d[5] = bcd_inc(dig_q[5], HR_H_MAX);
            if (dig_d[5] == HR_H_MAX && dig_q[4] > HR_L_MAX_24) begin
              dig_d[4] = HR_L_MAX_24;
            end
          end
          default: ;
        endcase
      end
    end

    blink_low = (ms_cnt_d < MS_HALF);
    disp_d    = (mode_d == MODE_RUN) ? DP_RUN : ~({5'b0, blink_low} << cursor_d);
  end

  always_ff @(posedge SYS_CLK or negedge EXT_RST_N) begin
    if (!EXT_RST_N) begin
      mode_q   <= MODE_RUN;
      cursor_q <= 3'd0;
      ms_cnt_q <= '0;
      dig_q    <= '0;
      disp_q   <= DP_RUN;
    end else begin
      mode_q   <= mode_d;
      cursor_q <= cursor_d;
      ms_cnt_q <= ms_cnt_d;
      dig_q    <= dig_d;
      disp_q   <= disp_d;
    end
  end

  assign COUNT_SECL = dig_q[0];
  assign COUNT_SECH = dig_q[1];
  assign COUNT_MINL = dig_q[2];
  assign COUNT_MINH = dig_q[3];
  assign COUNT_HRL  = dig_q[4];
  assign COUNT_HRH  = dig_q[5];
  assign DISP_P     = disp_q;

endmodule

// File: tb/tb_time_count.sv
// Directed bench for time_count with a shrunk timebase (4 clocks/ms, 4 ms/s).
module tb_time_count;

  localparam int MS_DIV     = 4;
  localparam int MS_PER_SEC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       set_r = 1'b0, left_r = 1'b0, right_r = 1'b0, up_r = 1'b0;
  logic       ms_f;
  logic [3:0] secl, sech, minl, minh, hrl, hrh;
  logic [5:0] disp_p;
  logic [23:0] t_now;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  time_count #(.MS_DIV(MS_DIV), .MS_PER_SEC(MS_PER_SEC)) dut (
    .SYS_CLK    (clk),
    .EXT_RST_N  (rst_n),
    .SET_R      (set_r),
    .LEFT_R     (left_r),
    .RIGHT_R    (right_r),
    .UP_R       (up_r),
    .MS_F       (ms_f),
    .COUNT_SECL (secl),
    .COUNT_SECH (sech),
    .COUNT_MINL (minl),
    .COUNT_MINH (minh),
    .COUNT_HRL  (hrl),
    .COUNT_HRH  (hrh),
    .DISP_P     (disp_p)
  );

  assign t_now = {hrh, hrl, minh, minl, sech, secl};

  typedef struct {
    logic        s, l, r, u;
    int          rep;
    logic [23:0] t;
    logic [2:0]  cur;
    logic        set_m;
  } vec_t;

  vec_t vecs [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_dp(input string name, input logic set_m, input logic [2:0] cur);
    if (!set_m) chk(name, {26'd0, disp_p}, 32'h2b);
    else        chk(name, {26'd0, disp_p | (6'b1 << cur)}, 32'h3f);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic s, input logic l, input logic r, input logic u, input int rep);
    for (int k = 0; k < rep; k++) begin
      @(negedge clk);
      set_r = s; left_r = l; right_r = r; up_r = u;
      @(posedge clk);
      #1;
      set_r = 1'b0; left_r = 1'b0; right_r = 1'b0; up_r = 1'b0;
    end
  endtask

  task automatic wait_change(input logic [23:0] prev, output int n, output logic [23:0] val);
    int c;
    c   = 0;
    n   = 0;
    val = prev;
    while (n == 0 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (t_now !== prev) begin
        n   = c;
        val = t_now;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int low_cnt;
    int other_bad;
    logic [23:0] val;

    //          s     l     r     u    rep  time       cur   set
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 24'h000000, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h000000, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 24'h000000, 3'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 24'h000000, 3'd5, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h000000, 3'd0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6, 24'h000006, 3'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h000006, 3'd1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5, 24'h000056, 3'd1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h000056, 3'd2, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4, 24'h000456, 3'd2, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h000456, 3'd3, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 24'h003456, 3'd3, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h003456, 3'd4, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 24'h023456, 3'd4, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h023456, 3'd5, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 24'h123456, 3'd5, 1'b1};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 24'h123456, 3'd5, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 24'h123456, 3'd5, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 24'h123456, 3'd5, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h123456, 3'd5, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 24'h123456, 3'd0, 1'b1};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 24'h123459, 3'd0, 1'b1};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 24'h123450, 3'd0, 1'b1};
    vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 4, 24'h123450, 3'd4, 1'b1};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b1, 5, 24'h173450, 3'd4, 1'b1};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 24'h173450, 3'd5, 1'b1};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 24'h233450, 3'd5, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 24'h233450, 3'd4, 1'b1};
    vecs[28] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 24'h203450, 3'd4, 1'b1};
    vecs[29] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 24'h203450, 3'd3, 1'b1};

    // Reset state while held in reset.
    #12;
    chk("reset time", {8'd0, t_now}, 32'h0);
    chk("reset ms_f", {31'd0, ms_f}, 32'h0);
    chk_dp("reset disp_p", 1'b0, 3'd0);

    // Strobe cadence after release: high after edges 4, 8, 12.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ms_f edge %0d", k), {31'd0, ms_f}, {31'd0, (k % 4 == 0)});
    end

    do_reset();
    for (int i = 0; i < 30; i++) begin
      press(vecs[i].s, vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].rep);
      $display("vec %0d: time=%06h disp_p=%06b", i, t_now, disp_p);
      chk($sformatf("vec %0d time", i), {8'd0, t_now}, {8'd0, vecs[i].t});
      chk_dp($sformatf("vec %0d disp_p", i), vecs[i].set_m, vecs[i].cur);
    end

    // Frozen in SET across several second ticks, then one full blink period on cursor 3.
    repeat (40) @(posedge clk);
    #1;
    chk("set frozen time", {8'd0, t_now}, 32'h203450);
    low_cnt   = 0;
    other_bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (!disp_p[3]) low_cnt++;
      if ((disp_p | 6'b001000) != 6'h3f) other_bad++;
    end
    chk("blink low cycles", low_cnt, 8);
    chk("blink other bits", other_bad, 0);

    // Asynchronous reset mid-cycle, sampled before the next rising edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: time=%06h disp_p=%06b ms_f=%0b", t_now, disp_p, ms_f);
    chk("async rst time", {8'd0, t_now}, 32'h0);
    chk("async rst disp_p", {26'd0, disp_p}, 32'h2b);
    chk("async rst ms_f", {31'd0, ms_f}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Preload 23:59:58 and run across midnight.
    press(1'b1, 1'b0, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b0, 1'b1, 8);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b0, 1'b1, 5);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b0, 1'b1, 9);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b0, 1'b1, 5);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b0, 1'b1, 3);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b0, 1'b1, 2);
    chk("preload time", {8'd0, t_now}, 32'h235958);
    press(1'b1, 1'b0, 1'b0, 1'b0, 1);
    chk_dp("run disp_p after exit", 1'b0, 3'd0);

    wait_change(24'h235958, n, val);
    $display("tick 1: after %0d cycles time=%06h", n, val);
    chk("first tick latency", {31'd0, (n >= 13 && n <= 16)}, 32'h1);
    chk("first tick time", {8'd0, val}, 32'h235959);
    wait_change(24'h235959, n, val);
    $display("tick 2: after %0d cycles time=%06h", n, val);
    chk("second tick period", n, 16);
    chk("midnight wrap time", {8'd0, val}, 32'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
